accel_avg_filter: RTL and testbench
===================================

Name: accel_avg_filter

Overview:
- Parametrised multi-channel accelerometer conditioner; sits between the raw accelerometer sampler and the NIOS sample ports.
- Keeps a per-channel moving average over 2^LOG2_DEPTH samples and presents averaged vectors through a valid/ready register.
- Raises a sticky motion interrupt when any channel's average changes by more than a programmable threshold.
- Generalises the fixed three-axis 16-bit path to NUM_CH channels of DATA_W bits.

Parameters:
- NUM_CH, 3, number of channels (x, y, z by default).
- DATA_W, 16, sample width; two's complement.
- LOG2_DEPTH, 3, log2 of averaging window (DEPTH = 8).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset: synchronous, active-low.
- sample_valid  in  1  one-cycle strobe; sample_data is valid.
- sample_data  in  NUM_CH*DATA_W  packed samples; ch0 in the LSBs.
- flush  in  1  clears the window and fill count.
- avg_valid  out  1  averaged vector is available.
- avg_ready  in  1  consumer accepts.
- avg_data  out  NUM_CH*DATA_W  packed averages.
- overrun  out  1  sticky: an unaccepted result was overwritten.
- threshold  in  DATA_W  unsigned motion threshold.
- motion_irq  out  1  sticky motion flag.
- irq_clear  in  1  clears motion_irq and overrun.

Behaviour:
- Reset, sampled on the clk_clk edge while reset_reset_n=0:
  - All outputs are 0.
  - Buffers, sums, fill count, prev-average-valid flag and pipeline all clear.
  - Reset mid-operation discards any in-flight result.
- Per channel:
  - Circular buffer of DEPTH entries, a write pointer and a running sum of width DATA_W+LOG2_DEPTH.
  - On sample_valid: sum <= sum + new - oldest; the buffer entry at the pointer is overwritten; the pointer wraps DEPTH-1 to 0.
  - The oldest entry reads as 0 until the buffer has been filled once.
- Fill count saturates at DEPTH. A result is produced only on samples for which the count after update equals DEPTH: the DEPTH-th sample and every later one.
- Average = sum >>> LOG2_DEPTH (arithmetic shift, floor toward -inf), truncated to DATA_W. This is exact: the magnitude cannot exceed DATA_W range.
- Latency: sample_valid at cycle t gives avg_valid=1 at t+2. Stage 1 updates the sum; stage 2 shifts and loads the output register.
- Throughput: sample_valid accepted every cycle; there is no input backpressure.
- Output handshake:
  - avg_valid stays high, with avg_data stable, until a cycle with avg_ready=1, which clears it.
  - A new result arriving while avg_valid=1 and avg_ready=0 overwrites avg_data, keeps avg_valid=1, and sets overrun.
  - A new result in the same cycle as an accept loads, and avg_valid stays 1 with no overrun.
- Motion detect:
  - Each produced average is compared with the previous produced average of the same channel.
  - If |new - prev| > threshold for any channel (DATA_W+1-bit signed difference), motion_irq is set.
  - There is no comparison for the first result after reset or flush.
  - irq_clear and a set in the same cycle: the set wins.
- flush:
  - Clears sums, buffers, pointer, fill count, the prev-average-valid flag and the stage-1 result.
  - Leaves avg_valid/avg_data and the sticky flags unchanged.
  - flush and sample_valid in the same cycle: flush wins and the sample is dropped.

Decomposition:
- Shared package accel_pkg holds:
  - DEFAULT_NUM_CH, DEFAULT_DATA_W, DEFAULT_LOG2_DEPTH.
  - The sum-width function DATA_W+LOG2_DEPTH.
  - Channel slice helpers (index to bit offset).
- One sub-module accel_ch_avg: per-channel buffer, pointer and running sum, with the stage-1 registered sum out. It is instantiated NUM_CH times under a generate loop.
- The top level owns fill count, output register, handshake and motion compare.

Test Plan:
- Defaults, avg_ready=1, eight samples of (100, -200, 7) on consecutive cycles -> single avg_valid 2 cycles after the 8th, avg_data=(100, -200, 7); no result before.
- ch0 seven samples 0 then -1 -> average -1 (floor), not 0; ch1 all 32767 -> 32767 (no overflow).
- avg_ready=0 after fill, two further samples -> avg_data holds the second result, overrun=1; avg_ready pulse -> avg_valid=0 next cycle.
- threshold=50, ch2 filled with 0, then one sample of 800 -> averages 0 then 100 -> motion_irq=1; irq_clear -> 0; with threshold=100 the same step -> no irq.
- flush after 5 samples, then 8 samples of 10 -> first result is 10, produced only after those 8 samples, with no motion compare against pre-flush data.
- reset_reset_n low for 1 cycle during fill, and separately during a pending avg_valid -> all outputs 0 next cycle; refill needs 8 fresh samples.

Source files
------------

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared defaults and width/slice helpers for the accelerometer averaging filter
package accel_pkg;

  localparam int DEFAULT_NUM_CH     = 3;
  localparam int DEFAULT_DATA_W     = 16;
  localparam int DEFAULT_LOG2_DEPTH = 3;

  function automatic int sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic int ch_lo(input int ch, input int data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/accel_avg_filter_if.sv
// rtl/accel_avg_filter_if.sv - sample input strobe and averaged-vector valid/ready bundle
interface accel_avg_filter_if
  import accel_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic                     sample_valid;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic                     avg_valid;
  logic                     avg_ready;
  logic [NUM_CH*DATA_W-1:0] avg_data;

  modport master (output sample_valid, sample_data, avg_ready, input avg_valid, avg_data);
  modport slave  (input sample_valid, sample_data, avg_ready, output avg_valid, avg_data);

endinterface

// File: rtl/accel_ch_avg.sv
// rtl/accel_ch_avg.sv - one channel: circular sample window and registered running sum
module accel_ch_avg
  import accel_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH,
  localparam int SUM_W     = sum_width(DATA_W, LOG2_DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [SUM_W-1:0]  sum
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic signed [DATA_W-1:0] buf_q [DEPTH];
  logic [LOG2_DEPTH-1:0]    ptr;
  logic signed [SUM_W-1:0]  next_sum;

  // Cleared entries make the oldest sample read as zero until the window has wrapped once.
  always_comb begin
    next_sum = sum + SUM_W'(sample) - SUM_W'(buf_q[ptr]);
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr <= '0;
      sum <= '0;
    end else if (sample_valid) begin
      buf_q[ptr] <= sample;
      ptr        <= ptr + 1'b1;
      sum        <= next_sum;
    end
  end

endmodule

// File: rtl/accel_avg_filter.sv
// rtl/accel_avg_filter.sv - multi-channel moving-average conditioner with output register and motion detect
module accel_avg_filter
  import accel_pkg::*;
#(
  parameter int NUM_CH     = DEFAULT_NUM_CH,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int LOG2_DEPTH = DEFAULT_LOG2_DEPTH
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  accel_avg_filter_if.slave  bus,
  input  logic               flush,
  output logic               overrun,
  input  logic [DATA_W-1:0]  threshold,
  output logic               motion_irq,
  input  logic               irq_clear
);

  localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] DEPTH_C = {1'b1, {LOG2_DEPTH{1'b0}}};

  logic signed [SUM_W-1:0]  sum_ch [NUM_CH];
  logic [LOG2_DEPTH:0]      fill;
  logic [LOG2_DEPTH:0]      fill_next;
  logic                     s1_valid;
  logic                     load;
  logic                     motion;
  logic                     prev_valid;
  logic [NUM_CH*DATA_W-1:0] prev_q;
  logic [NUM_CH*DATA_W-1:0] avg_new;
  logic                     avg_valid_q;
  logic [NUM_CH*DATA_W-1:0] avg_data_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    accel_ch_avg #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ch (
      .clk          (clk_clk),
      .resetn       (reset_reset_n),
      .flush        (flush),
      .sample_valid (bus.sample_valid),
      .sample       (bus.sample_data[ch_lo(g, DATA_W) +: DATA_W]),
      .sum          (sum_ch[g])
    );
  end

  assign fill_next = (fill == DEPTH_C) ? fill : fill + 1'b1;
  // A flush in the same cycle also discards the stage-1 result.
  assign load      = s1_valid && !flush;

  always_comb begin
    logic [DATA_W-1:0] avg;
    logic [DATA_W-1:0] prv;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   mag;
    avg     = '0;
    prv     = '0;
    diff    = '0;
    mag     = '0;
    avg_new = '0;
    motion  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      avg  = DATA_W'(sum_ch[c] >>> LOG2_DEPTH);
      prv  = prev_q[ch_lo(c, DATA_W) +: DATA_W];
      diff = {avg[DATA_W-1], avg} - {prv[DATA_W-1], prv};
      mag  = diff[DATA_W] ? -diff : diff;
      if (mag > {1'b0, threshold}) motion = 1'b1;
      avg_new[ch_lo(c, DATA_W) +: DATA_W] = avg;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      fill        <= '0;
      s1_valid    <= 1'b0;
      prev_valid  <= 1'b0;
      prev_q      <= '0;
      avg_valid_q <= 1'b0;
      avg_data_q  <= '0;
      overrun     <= 1'b0;
      motion_irq  <= 1'b0;
    end else begin
      if (flush) begin
        fill       <= '0;
        s1_valid   <= 1'b0;
        prev_valid <= 1'b0;
      end else begin
        if (bus.sample_valid) fill <= fill_next;
        s1_valid <= bus.sample_valid && (fill_next == DEPTH_C);
      end

      if (load) begin
        avg_data_q  <= avg_new;
        avg_valid_q <= 1'b1;
        prev_q      <= avg_new;
        prev_valid  <= 1'b1;
      end else if (bus.avg_ready) begin
        avg_valid_q <= 1'b0;
      end

      // Sticky flags: a new set outranks irq_clear in the same cycle.
      if (load && avg_valid_q && !bus.avg_ready) overrun <= 1'b1;
      else if (irq_clear)                        overrun <= 1'b0;

      if (load && prev_valid && motion) motion_irq <= 1'b1;
      else if (irq_clear)               motion_irq <= 1'b0;
    end
  end

  assign bus.avg_valid = avg_valid_q;
  assign bus.avg_data  = avg_data_q;

endmodule

// File: tb/tb_accel_avg_filter.sv
// tb/tb_accel_avg_filter.sv - directed self-checking bench for accel_avg_filter
module tb_accel_avg_filter;

  localparam int NC = 3;
  localparam int DW = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          irq_clear = 1'b0;
  logic [DW-1:0] threshold = '1;
  logic          overrun;
  logic          motion_irq;
  int            n_tests = 0;
  int            n_fail = 0;

  accel_avg_filter_if #(.NUM_CH(NC), .DATA_W(DW)) bus ();

  accel_avg_filter #(.NUM_CH(NC), .DATA_W(DW), .LOG2_DEPTH(3)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .flush         (flush),
    .overrun       (overrun),
    .threshold     (threshold),
    .motion_irq    (motion_irq),
    .irq_clear     (irq_clear)
  );

  always #5 clk_clk = ~clk_clk;

  function automatic logic [NC*DW-1:0] pack(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
    return {c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic send(input logic [NC*DW-1:0] d);
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    tick();
    tick();
    reset_reset_n = 1'b1;
    n_tests++;
    if ({bus.avg_valid, overrun, motion_irq} !== 3'b000 || bus.avg_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b o=%b m=%b d=%h exp all 0",
               bus.avg_valid, overrun, motion_irq, bus.avg_data);
    end
  endtask

  task automatic test_fill();
    logic [NC*DW-1:0] exp_d;
    exp_d = pack(16'sd100, -16'sd200, 16'sd7);
    for (int i = 0; i < 8; i++) begin
      send(exp_d);
      n_tests++;
      if (bus.avg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_early_valid sample %0d got %b exp 0", i, bus.avg_valid);
      end
    end
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== exp_d) begin
      n_fail++;
      $display("FAIL fill_result got v=%b d=%h exp v=1 d=%h", bus.avg_valid, bus.avg_data, exp_d);
    end
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_accept got %b exp 0", bus.avg_valid);
    end
  endtask

  task automatic test_floor();
    logic [NC*DW-1:0] exp_d;
    exp_d = pack(16'hFFFF, 16'h7FFF, 16'h0000);
    do_flush();
    for (int i = 0; i < 7; i++) send(pack(16'h0000, 16'h7FFF, 16'h0000));
    send(pack(16'hFFFF, 16'h7FFF, 16'h0000));
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== exp_d) begin
      n_fail++;
      $display("FAIL floor_result got v=%b d=%h exp v=1 d=%h", bus.avg_valid, bus.avg_data, exp_d);
    end
    tick();
  endtask

  task automatic test_overrun();
    do_flush();
    for (int i = 0; i < 8; i++) send(pack(16'sd80, 16'sd8, -16'sd8));
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== pack(16'sd80, 16'sd8, -16'sd8)) begin
      n_fail++;
      $display("FAIL ovr_first got v=%b d=%h exp v=1 d=%h", bus.avg_valid, bus.avg_data,
               pack(16'sd80, 16'sd8, -16'sd8));
    end
    tick();
    bus.avg_ready = 1'b0;
    send(pack(16'sd160, 16'sd8, -16'sd8));
    send(pack(16'sd240, 16'sd8, -16'sd8));
    n_tests++;
    if (bus.avg_valid !== 1'b1 || overrun !== 1'b0 || bus.avg_data !== pack(16'sd90, 16'sd8, -16'sd8)) begin
      n_fail++;
      $display("FAIL ovr_a got v=%b o=%b d=%h exp v=1 o=0 d=%h", bus.avg_valid, overrun,
               bus.avg_data, pack(16'sd90, 16'sd8, -16'sd8));
    end
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || overrun !== 1'b1 || bus.avg_data !== pack(16'sd110, 16'sd8, -16'sd8)) begin
      n_fail++;
      $display("FAIL ovr_b got v=%b o=%b d=%h exp v=1 o=1 d=%h", bus.avg_valid, overrun,
               bus.avg_data, pack(16'sd110, 16'sd8, -16'sd8));
    end
    bus.avg_ready = 1'b1;
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_accept got v=%b o=%b exp v=0 o=1", bus.avg_valid, overrun);
    end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
  endtask

  task automatic test_motion(input logic [DW-1:0] thr, input logic exp_irq);
    threshold = thr;
    do_flush();
    for (int i = 0; i < 8; i++) send('0);
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || motion_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL motion_base thr=%0d got v=%b m=%b exp v=1 m=0", thr, bus.avg_valid, motion_irq);
    end
    send(pack(16'sd0, 16'sd0, 16'sd800));
    tick();
    n_tests++;
    if (bus.avg_data !== pack(16'sd0, 16'sd0, 16'sd100) || motion_irq !== exp_irq) begin
      n_fail++;
      $display("FAIL motion_step thr=%0d got d=%h m=%b exp d=%h m=%b", thr, bus.avg_data,
               motion_irq, pack(16'sd0, 16'sd0, 16'sd100), exp_irq);
    end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    n_tests++;
    if (motion_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL motion_clear got %b exp 0", motion_irq);
    end
  endtask

  task automatic test_flush();
    threshold = '1;
    for (int i = 0; i < 5; i++) send(pack(16'sd500, 16'sd500, 16'sd500));
    tick();
    tick();
    do_flush();
    threshold = '0;
    for (int i = 0; i < 8; i++) begin
      send(pack(16'sd10, 16'sd10, 16'sd10));
      n_tests++;
      if (bus.avg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_early_valid sample %0d got %b exp 0", i, bus.avg_valid);
      end
    end
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== pack(16'sd10, 16'sd10, 16'sd10) || motion_irq !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_result got v=%b d=%h m=%b exp v=1 d=%h m=0", bus.avg_valid,
               bus.avg_data, motion_irq, pack(16'sd10, 16'sd10, 16'sd10));
    end
    tick();
  endtask

  task automatic test_reset_mid();
    threshold = '0;
    for (int i = 0; i < 4; i++) send(pack(16'sd1, 16'sd1, 16'sd1));
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    n_tests++;
    if ({bus.avg_valid, overrun, motion_irq} !== 3'b000 || bus.avg_data !== '0) begin
      n_fail++;
      $display("FAIL rst_fill_outputs got v=%b o=%b m=%b d=%h exp all 0",
               bus.avg_valid, overrun, motion_irq, bus.avg_data);
    end
    for (int i = 0; i < 7; i++) begin
      send(pack(16'sd40, 16'sd40, 16'sd40));
      tick();
      n_tests++;
      if (bus.avg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_refill_early sample %0d got %b exp 0", i, bus.avg_valid);
      end
    end
    send(pack(16'sd40, 16'sd40, 16'sd40));
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b1 || bus.avg_data !== pack(16'sd40, 16'sd40, 16'sd40)) begin
      n_fail++;
      $display("FAIL rst_refill_result got v=%b d=%h exp v=1 d=%h", bus.avg_valid, bus.avg_data,
               pack(16'sd40, 16'sd40, 16'sd40));
    end
    bus.avg_ready = 1'b0;
    send(pack(16'sd80, 16'sd40, 16'sd40));
    tick();
    n_tests++;
    if (bus.avg_data !== pack(16'sd45, 16'sd40, 16'sd40) || overrun !== 1'b1 || motion_irq !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pending got d=%h o=%b m=%b exp d=%h o=1 m=1", bus.avg_data, overrun,
               motion_irq, pack(16'sd45, 16'sd40, 16'sd40));
    end
    send(pack(16'sd40, 16'sd40, 16'sd40));
    reset_reset_n = 1'b0;
    tick();
    reset_reset_n = 1'b1;
    n_tests++;
    if ({bus.avg_valid, overrun, motion_irq} !== 3'b000 || bus.avg_data !== '0) begin
      n_fail++;
      $display("FAIL rst_pending_outputs got v=%b o=%b m=%b d=%h exp all 0",
               bus.avg_valid, overrun, motion_irq, bus.avg_data);
    end
    tick();
    n_tests++;
    if (bus.avg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_inflight got %b exp 0", bus.avg_valid);
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.avg_ready    = 1'b1;
    test_reset();
    test_fill();
    test_floor();
    test_overrun();
    test_motion(16'd50, 1'b1);
    test_motion(16'd100, 1'b0);
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
